// File: rtl/epu_arb_pkg.sv
// Shared types for the input/output SRAM arbiter, plus the SRAM write-strobe encoding.
// WRITE_ENB/WRITE_DIS are only defined here if the codebase has not defined them already.
`ifndef WRITE_ENB
`define WRITE_ENB 1'b0
`endif
`ifndef WRITE_DIS
`define WRITE_DIS 1'b1
`endif

package epu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        HOST_BURST = 2'd1,
        EPU_RUN    = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_HOST = 1'b0,
        OWN_EPU  = 1'b1
    } arb_owner_t;

    // Width of the EPU starvation hold counter.
    localparam int HOLD_W = 8;

endpackage

// File: rtl/inout_sram_arbiter_if.sv
// Requester-side beat bus of the SRAM arbiter: request/beat fields in, grant and read return out.
// The EPU carries single beats and therefore binds through slave_beat, which omits last.
interface inout_sram_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              last;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata, last,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, last,
        output gnt, rvalid, rdata
    );

    modport slave_beat (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/inout_sram_arbiter_hold.sv
// Counts consecutive EPU beats granted while the host waits; expire flags the final allowed beat.
// Only built with ARB_STARVE_GUARD_EN defined, which is the only configuration that instantiates it.
`ifdef ARB_STARVE_GUARD_EN
module arb_hold_counter
    import epu_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic expire
);

    logic [HOLD_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == HOLD_W'(MAX_HOLD - 1));

endmodule
`endif

// File: rtl/inout_sram_arbiter.sv
// Arbitrates the 384 KB InOut SRAM between locked host bursts and single-beat EPU accesses.
// Define ARB_STARVE_GUARD_EN to force a handoff to a waiting host after MAX_HOLD EPU beats.
module inout_sram_arbiter
    import epu_arb_pkg::*;
#(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    inout_sram_arbiter_if.slave      host,
    inout_sram_arbiter_if.slave_beat epu,
    output logic                  sram_cs,
    output logic                  sram_oe,
    output logic                  sram_w_req,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_wdata,
    input  logic [DATA_W-1:0]     sram_rdata
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("inout_sram_arbiter: MAX_HOLD must be within 1..255");
    end

    arb_state_t state, state_nxt;
    arb_owner_t rd_owner;
    logic       rd_pend;
    logic       host_gnt, epu_gnt;
    logic       host_acc, epu_acc;
    logic       hold_expire;
    logic       host_rvalid, epu_rvalid;

    assign host_gnt = (state == HOST_BURST);
    assign epu_gnt  = (state == EPU_RUN);
    assign host_acc = host_gnt && host.req;
    assign epu_acc  = epu_gnt && epu.req;

`ifdef ARB_STARVE_GUARD_EN
    arb_hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .inc    (epu_acc && host.req),
        .clr    (!host.req || (epu_gnt && state_nxt != EPU_RUN)),
        .expire (hold_expire)
    );
`else
    assign hold_expire = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (host.req)     state_nxt = HOST_BURST;
                else if (epu.req) state_nxt = EPU_RUN;
            end
            HOST_BURST: begin
                if (host_acc && host.last) state_nxt = epu.req ? EPU_RUN : IDLE;
            end
            EPU_RUN: begin
                if (!epu.req)                     state_nxt = host.req ? HOST_BURST : IDLE;
                else if (hold_expire && host.req) state_nxt = HOST_BURST;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The SRAM is driven only in cycles that accept a beat; otherwise it sits deselected at zero.
    always_comb begin
        sram_cs    = 1'b0;
        sram_oe    = 1'b0;
        sram_w_req = `WRITE_DIS;
        sram_addr  = '0;
        sram_wdata = '0;
        if (host_acc) begin
            sram_cs    = 1'b1;
            sram_oe    = !host.we;
            sram_w_req = host.we ? `WRITE_ENB : `WRITE_DIS;
            sram_addr  = host.addr;
            sram_wdata = host.wdata;
        end else if (epu_acc) begin
            sram_cs    = 1'b1;
            sram_oe    = !epu.we;
            sram_w_req = epu.we ? `WRITE_ENB : `WRITE_DIS;
            sram_addr  = epu.addr;
            sram_wdata = epu.wdata;
        end
    end

    // The issuer is remembered so a read in the last owned cycle still returns to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend  <= 1'b0;
            rd_owner <= OWN_HOST;
        end else begin
            rd_pend  <= (host_acc && !host.we) || (epu_acc && !epu.we);
            rd_owner <= epu_acc ? OWN_EPU : OWN_HOST;
        end
    end

    assign host_rvalid = rd_pend && (rd_owner == OWN_HOST);
    assign epu_rvalid  = rd_pend && (rd_owner == OWN_EPU);

    assign host.gnt    = host_gnt;
    assign host.rvalid = host_rvalid;
    assign host.rdata  = host_rvalid ? sram_rdata : '0;
    assign epu.gnt     = epu_gnt;
    assign epu.rvalid  = epu_rvalid;
    assign epu.rdata   = epu_rvalid ? sram_rdata : '0;

endmodule

// File: tb/tb_inout_sram_arbiter.sv
// Directed bench for inout_sram_arbiter with a behavioural one-cycle-read SRAM.
// Expectations follow ARB_STARVE_GUARD_EN, so the bench is built with the same define set as the RTL.
`ifndef WRITE_ENB
`define WRITE_ENB 1'b0
`endif
`ifndef WRITE_DIS
`define WRITE_DIS 1'b1
`endif

module tb_inout_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sram_cs, sram_oe, sram_w_req;
    logic [17:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [31:0] mem [0:1023];

    int checks   = 0;
    int failures = 0;

    inout_sram_arbiter_if host_bus ();
    inout_sram_arbiter_if epu_bus ();

    inout_sram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .host       (host_bus),
        .epu        (epu_bus),
        .sram_cs    (sram_cs),
        .sram_oe    (sram_oe),
        .sram_w_req (sram_w_req),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    // SRAM stand-in: preloads a per-address pattern during reset, then write-at-edge and registered read.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
            sram_rdata <= '0;
        end else begin
            if (sram_cs && sram_w_req == `WRITE_ENB) mem[sram_addr[9:0]] <= sram_wdata;
            if (sram_cs && sram_oe) sram_rdata <= mem[sram_addr[9:0]];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        int n;
        bit hit;

        host_bus.req = 0; host_bus.we = 0; host_bus.addr = '0; host_bus.wdata = '0; host_bus.last = 0;
        epu_bus.req  = 0; epu_bus.we  = 0; epu_bus.addr  = '0; epu_bus.wdata  = '0; epu_bus.last  = 0;

        // Reset values
        tick(); tick(); tick();
        check("rst_host_gnt", host_bus.gnt, 0);
        check("rst_epu_gnt", epu_bus.gnt, 0);
        check("rst_host_rvalid", host_bus.rvalid, 0);
        check("rst_epu_rvalid", epu_bus.rvalid, 0);
        check("rst_cs", sram_cs, 0);
        check("rst_oe", sram_oe, 0);
        check("rst_w_req", sram_w_req, `WRITE_DIS);
        check("rst_addr", sram_addr, 0);
        check("rst_wdata", sram_wdata, 0);
        check("rst_host_rdata", host_bus.rdata, 0);
        check("rst_epu_rdata", epu_bus.rdata, 0);
        rst = 0;
        tick();

        // Host 4-beat write burst then 4-beat read burst
        host_bus.req = 1; host_bus.we = 1; host_bus.addr = 18'h100; host_bus.wdata = 32'hA0;
        settle();
        check("t1_no_gnt_same_cycle", host_bus.gnt, 0);
        check("t1_cs_before_gnt", sram_cs, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            host_bus.addr = 18'h100 + 18'(i); host_bus.wdata = 32'hA0 + 32'(i); host_bus.last = (i == 3);
            settle();
            check("t1_wr_host_gnt", host_bus.gnt, 1);
            check("t1_wr_epu_gnt", epu_bus.gnt, 0);
            check("t1_wr_cs", sram_cs, 1);
            check("t1_wr_oe", sram_oe, 0);
            check("t1_wr_w_req", sram_w_req, `WRITE_ENB);
            check("t1_wr_addr", sram_addr, 32'h100 + 32'(i));
            check("t1_wr_wdata", sram_wdata, 32'hA0 + 32'(i));
            tick();
        end
        host_bus.req = 0; host_bus.last = 0;
        settle();
        check("t1_idle_after_last", host_bus.gnt, 0);
        host_bus.req = 1; host_bus.we = 0; host_bus.addr = 18'h100;
        tick();
        for (int i = 0; i < 4; i++) begin
            host_bus.addr = 18'h100 + 18'(i); host_bus.last = (i == 3);
            settle();
            check("t1_rd_cs", sram_cs, 1);
            check("t1_rd_oe", sram_oe, 1);
            check("t1_rd_w_req", sram_w_req, `WRITE_DIS);
            check("t1_rd_epu_gnt", epu_bus.gnt, 0);
            check("t1_rd_rvalid", host_bus.rvalid, (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) check("t1_rd_rdata", host_bus.rdata, 32'hA0 + 32'(i - 1));
            tick();
        end
        host_bus.req = 0; host_bus.last = 0;
        settle();
        check("t1_rd_last_rvalid", host_bus.rvalid, 1);
        check("t1_rd_last_rdata", host_bus.rdata, 32'hA3);
        check("t1_rd_epu_rvalid", epu_bus.rvalid, 0);
        tick();
        check("t1_rvalid_single_pulse", host_bus.rvalid, 0);
        check("t1_rdata_cleared", host_bus.rdata, 0);

        // Simultaneous requests: host first, EPU right after host_last, host read returns after handoff
        host_bus.req = 1; host_bus.we = 0; host_bus.addr = 18'h100; host_bus.last = 1;
        epu_bus.req = 1; epu_bus.we = 1; epu_bus.addr = 18'h300; epu_bus.wdata = 32'h22;
        settle();
        check("t2_no_gnt_yet", {host_bus.gnt, epu_bus.gnt}, 0);
        tick();
        check("t2_host_wins", {host_bus.gnt, epu_bus.gnt}, 2'b10);
        check("t2_host_addr", sram_addr, 32'h100);
        tick();
        host_bus.req = 0; host_bus.last = 0;
        settle();
        check("t2_epu_no_gap", {host_bus.gnt, epu_bus.gnt}, 2'b01);
        check("t2_host_rvalid_after_handoff", host_bus.rvalid, 1);
        check("t2_host_rdata_after_handoff", host_bus.rdata, 32'hA0);
        check("t2_epu_rvalid_quiet", epu_bus.rvalid, 0);
        check("t2_epu_rdata_zero", epu_bus.rdata, 0);
        check("t2_epu_wr_strobe", {sram_cs, sram_oe, sram_w_req}, {2'b10, `WRITE_ENB});
        check("t2_epu_wr_addr", sram_addr, 32'h300);
        check("t2_epu_wr_data", sram_wdata, 32'h22);
        tick();
        epu_bus.req = 0;
        settle();
        check("t2_epu_gnt_held", epu_bus.gnt, 1);
        check("t2_cs_without_req", sram_cs, 0);
        tick();
        check("t2_back_to_idle", epu_bus.gnt, 0);

        // EPU streams reads while the host waits
        epu_bus.req = 1; epu_bus.we = 0; epu_bus.addr = 18'h40;
        tick();
        host_bus.req = 1; host_bus.we = 0; host_bus.addr = 18'h41; host_bus.last = 1;
        n = 0;
        hit = 0;
        for (int c = 0; c < 20; c++) begin
            epu_bus.addr = 18'h40 + 18'(n);
            settle();
            if (host_bus.gnt) begin
                hit = 1;
                break;
            end
            if (epu_bus.gnt) n++;
            tick();
        end
`ifdef ARB_STARVE_GUARD_EN
        check("t3_handoff_seen", 32'(hit), 1);
        check("t3_epu_beats", n, 16);
        check("t3_gnt_after_hold", {host_bus.gnt, epu_bus.gnt}, 2'b10);
        check("t4_epu_rvalid_at_handoff", epu_bus.rvalid, 1);
        check("t4_epu_rdata_at_handoff", epu_bus.rdata, pat(32'h40 + 15));
        check("t4_host_rvalid_quiet", host_bus.rvalid, 0);
        check("t4_host_rdata_zero", host_bus.rdata, 0);
        check("t3_host_addr", sram_addr, 32'h41);
        tick();
        check("t3_epu_regains", epu_bus.gnt, 1);
        check("t3_host_rdata", host_bus.rdata, pat(32'h41));
        host_bus.req = 0; host_bus.last = 0; epu_bus.req = 0;
        tick();
        tick();
`else
        check("t3_no_forced_handoff", 32'(hit), 0);
        check("t3_epu_beats", n, 20);
        check("t3_gnt_kept", {host_bus.gnt, epu_bus.gnt}, 2'b01);
        epu_bus.req = 0;
        settle();
        check("t3_epu_gnt_held", epu_bus.gnt, 1);
        check("t3_epu_rvalid", epu_bus.rvalid, 1);
        check("t3_epu_rdata", epu_bus.rdata, pat(32'h40 + 19));
        check("t3_cs_no_beat", sram_cs, 0);
        tick();
        check("t3_host_after_drop", {host_bus.gnt, epu_bus.gnt}, 2'b10);
        check("t3_host_addr", sram_addr, 32'h41);
        tick();
        check("t3_host_rdata", host_bus.rdata, pat(32'h41));
        host_bus.req = 0; host_bus.last = 0;
        tick();
`endif
        check("t3_idle", {host_bus.gnt, epu_bus.gnt}, 0);

        // Host stalls mid-burst with the EPU requesting
        host_bus.req = 1; host_bus.we = 1; host_bus.addr = 18'h180; host_bus.wdata = 32'h77; host_bus.last = 0;
        tick();
        settle();
        check("t5_first_beat_cs", sram_cs, 1);
        tick();
        host_bus.req = 0;
        epu_bus.req = 1; epu_bus.we = 0; epu_bus.addr = 18'h40;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t5_stall_gnts", {host_bus.gnt, epu_bus.gnt}, 2'b10);
            check("t5_stall_cs", sram_cs, 0);
            tick();
        end
        host_bus.req = 1; host_bus.addr = 18'h181; host_bus.wdata = 32'h78; host_bus.last = 1;
        settle();
        check("t5_resume_cs", sram_cs, 1);
        check("t5_resume_addr", sram_addr, 32'h181);
        tick();
        host_bus.req = 0; host_bus.last = 0;
        settle();
        check("t5_epu_after_burst", {host_bus.gnt, epu_bus.gnt}, 2'b01);
        epu_bus.req = 0;
        tick();
        tick();
        check("t5_idle", {host_bus.gnt, epu_bus.gnt}, 0);

        // Asynchronous reset during a pending host read
        host_bus.req = 1; host_bus.we = 0; host_bus.addr = 18'h100; host_bus.last = 0;
        tick();
        tick();
        check("t6_pending_rvalid", host_bus.rvalid, 1);
        check("t6_pending_gnt", host_bus.gnt, 1);
        rst = 1;
        settle();
        check("t6_rst_gnt", {host_bus.gnt, epu_bus.gnt}, 0);
        check("t6_rst_rvalid", host_bus.rvalid, 0);
        check("t6_rst_rdata", host_bus.rdata, 0);
        check("t6_rst_sram", {sram_cs, sram_oe, sram_w_req}, {2'b00, `WRITE_DIS});
        check("t6_rst_addr", sram_addr, 0);
        host_bus.req = 0;
        tick();
        check("t6_no_late_rvalid", {host_bus.rvalid, epu_bus.rvalid}, 0);
        rst = 0;
        tick();
        check("t6_idle_after_rst", {host_bus.gnt, epu_bus.gnt}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inout_sram_arbiter.md
# inout_sram_arbiter

Arbitrates the single-port 384 KB input/output buffer SRAM between two requesters: the AXI-side host port, which issues locked bursts, and the EPU compute port, which issues single beats. Sits between the EPU wrapper/EPU and one `InOut_SRAM_384k` instance. Owns grant sequencing, SRAM control muxing, one-cycle read-data return routing and EPU starvation bounding.

## Interface
- `ADDR_W`, 18, SRAM word address width
- `DATA_W`, 32, data width
- `MAX_HOLD`, 16, maximum consecutive EPU beats while the host waits (range 1..255)

- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `host_req` in 1: host beat request
- `host_we` in 1: 1 = write, 0 = read
- `host_addr` in ADDR_W: word address
- `host_wdata` in DATA_W: write data
- `host_last` in 1: final beat of the burst
- `host_gnt` out 1: host owns the SRAM
- `host_rvalid` out 1: host read data valid
- `host_rdata` out DATA_W: host read data
- `epu_req`, `epu_we`, `epu_addr`, `epu_wdata` in: same meaning for the EPU
- `epu_gnt`, `epu_rvalid`, `epu_rdata` out: same meaning for the EPU
- `sram_cs`, `sram_oe` out 1: SRAM chip select and output enable
- `sram_w_req` out 1: write strobe, `WRITE_ENB`/`WRITE_DIS` encoding
- `sram_addr` out ADDR_W; `sram_wdata` out DATA_W; `sram_rdata` in DATA_W

## Operation
- States: IDLE, HOST_BURST, EPU_RUN.
- A beat is accepted in any cycle where `req && gnt` for the same port.
- `host_gnt` = (state == HOST_BURST). `epu_gnt` = (state == EPU_RUN). Both are decoded from registered state only.
- IDLE:
  - `host_req` → HOST_BURST.
  - Otherwise `epu_req` → EPU_RUN.
  - Simultaneous requests: host wins.
- HOST_BURST:
  - An accepted beat with `host_last` → EPU_RUN if `epu_req`, else IDLE.
  - If `host_req` is low, the host stalls and keeps the lock; the SRAM is left idle.
- EPU_RUN:
  - `epu_req` low → HOST_BURST if `host_req`, else IDLE.
  - Hold counter `hold_cnt` (8 bits) increments on each accepted EPU beat while `host_req` is high.
  - `hold_cnt` clears when `host_req` is low or on leaving EPU_RUN.
  - An accepted beat with `hold_cnt == MAX_HOLD-1` and `host_req` high → HOST_BURST.
- SRAM drive:
  - Accepted read: `cs=1`, `oe=1`, `WRITE_DIS`.
  - Accepted write: `cs=1`, `oe=0`, `WRITE_ENB`.
  - Address and data come from the owner.
  - No accepted beat: `cs=0`, `oe=0`, `WRITE_DIS`, `addr=0`, `wdata=0`.
- Read return:
  - Each accepted read registers `rd_pend` and `rd_owner`.
  - The next cycle routes `sram_rdata` to the owner's rdata and pulses its rvalid.
  - The non-owner's rdata stays 0.

## Timing
- Reset values: state IDLE; all `gnt`, `rvalid`, `cs`, `oe` = 0; `sram_w_req = WRITE_DIS`; addr, data and rdata outputs = 0; `hold_cnt = 0`; `rd_pend = 0`.
- Arbitration latency: a request in cycle N from IDLE is granted in N+1.
- Ownership handoff costs no idle cycle; the new owner's first beat can be accepted the cycle after the old owner's final beat.
- Read latency: exactly 1 cycle from acceptance to rvalid. Back-to-back reads produce back-to-back rvalid.
- A read accepted in the last cycle of ownership still returns to its issuer after ownership moves.
- Writes commit at the acceptance edge; there is no response.
- Reset mid-burst: the state machine aborts to IDLE asynchronously and any in-flight rvalid is dropped.

## Configuration
- `ARB_STARVE_GUARD_EN` defined: `MAX_HOLD` forced handoff is active as above.
- `ARB_STARVE_GUARD_EN` undefined: `hold_cnt` logic is removed and EPU_RUN is held until `epu_req` drops. The `MAX_HOLD` parameter is ignored.

## Structure
- Shared package `epu_arb_pkg`:
  - `arb_state_t` enum (IDLE=2'd0, HOST_BURST=2'd1, EPU_RUN=2'd2)
  - `arb_owner_t` enum (OWN_HOST, OWN_EPU)
- `WRITE_ENB`/`WRITE_DIS` remain in the existing defines.
- One sub-module, `arb_hold_counter`:
  - Inputs: inc, clr.
  - Output: `expire` = (count == MAX_HOLD-1).
  - Instantiated only under `ARB_STARVE_GUARD_EN`.

## Test plan
- Host 4-beat write burst to 0x100..0x103 with data 0xA0..0xA3, then a 4-beat read → `host_rvalid` pulses 1 cycle after each read acceptance with data 0xA0..0xA3; `epu_gnt` stays 0 throughout.
- `host_req` and `epu_req` both rise in the same IDLE cycle → `host_gnt` in the next cycle; after `host_last`, `epu_gnt` in the following cycle with no gap.
- EPU streams reads continuously while the host requests, `MAX_HOLD=16`, guard enabled → exactly 16 EPU beats are accepted, then `host_gnt`. With the guard disabled → EPU keeps the grant until `epu_req` drops.
- EPU read accepted in the same cycle the handoff to host occurs → `epu_rvalid` asserts with the correct data and `host_rvalid` stays 0.
- Host burst stalls (`host_req` low for 3 cycles mid-burst) with `epu_req` high → `host_gnt` held, `epu_gnt` 0, `sram_cs` 0 during the stall.
- `rst` asserted mid-burst during a pending read → outputs return to reset values immediately and no rvalid is produced.
